regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised register file with an integrated per-register pending-write scoreboard. Successor to the single-issue RV32I register file.
- Provides two combinational read ports with optional write-to-read bypass, one write-back port, and a hard-wired zero register.
- A per-register outstanding-write counter lets the decode/hazard stage stall on RAW hazards.
- Sits between decode (reads and issue) and write-back (writes and retire) in the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, at least 2).
- AW, $clog2(NREG), register address width (derived; do not override).
- CNT_W, 2, width of each per-register outstanding-write counter. Maximum outstanding writes per register = 2^CNT_W-1.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- reg_data1  out  XLEN  read data, port 1.
- reg_data2  out  XLEN  read data, port 2.
- rs1_busy  out  1  register rs1 has at least one outstanding write.
- rs2_busy  out  1  register rs2 has at least one outstanding write.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  AW  destination register of the issued instruction.
- iss_ready  out  1  issue can be accepted this cycle.
- reg_write  in  1  write-back enable; also retires one outstanding write on rd.
- rd  in  AW  write-back address.
- reg_data3  in  XLEN  write-back data.
- err_underflow  out  1  sticky flag: write-back arrived for a register whose counter was 0.

Behaviour:
- Reset (RST high, asynchronous):
  - All registers clear to 0.
  - All counters clear to 0.
  - err_underflow clears to 0.
  - Outputs during reset: reg_data* = 0, rs*_busy = 0, iss_ready = 1.
  - Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
- Register 0:
  - Always reads 0 and is never written; writes to rd=0 are dropped.
  - Register 0 never reports busy.
  - Issue to iss_rd=0 is accepted (iss_ready=1) with no counter change.
- Reads:
  - Combinational, zero latency.
  - With BYPASS=1, when reg_write=1, rd==rsN and rd!=0, reg_data N = reg_data3 in the same cycle.
  - With BYPASS=0, read data reflects the array contents before the clock edge.
- Writes:
  - On the rising edge, if reg_write=1 and rd!=0, the register at rd takes reg_data3.
- Outstanding-write counters (cnt[r], one per register r!=0):
  - iss_ready = !(iss_valid && iss_rd!=0 && cnt[iss_rd]==max && !(reg_write && rd==iss_rd)).
    A retire to the same register in the same cycle frees a slot.
  - An issue is accepted when iss_valid && iss_ready.
  - Per edge, for each register r: inc = accepted issue to r; dec = reg_write && rd==r && cnt[r]!=0.
  - cnt[r] becomes cnt[r] + inc - dec. Simultaneous inc and dec on the same register leaves cnt unchanged.
  - reg_write with cnt[rd]==0 and rd!=0: the data is still written, the counter stays 0, and err_underflow is set (sticky until reset).
- Busy flags:
  - rsN_busy = (cnt[rsN]!=0), evaluated on the current-cycle counter value.
  - With BYPASS=1, a write-back in the same cycle that drops the counter from 1 to 0 clears busy combinationally; the bypassed data is valid.
  - With BYPASS=0, busy follows the registered counter only.
- Widths: counters never wrap. Overflow is prevented by iss_ready, underflow by the cnt!=0 guard.

Decomposition:
- Shared package core_pkg holds:
  - XLEN_DEF = 32 and NREG_DEF = 32.
  - A typedef for the register-address type (logic [4:0]).
  - A typedef for the XLEN data word.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, full, nonzero and underflow outputs. It is instantiated NREG-1 times in a generate loop.
- The storage array and bypass muxes stay in the top module.

Test Plan:
- Reset clears state: write 0xDEADBEEF to x5, assert RST mid-cycle -> reg_data1 (rs1=5) = 0 immediately, before any clock edge; rs1_busy=0; iss_ready=1.
- Zero register: reg_write=1, rd=0, reg_data3=0x12345678, then read rs1=0 -> 0. iss_valid with iss_rd=0 -> iss_ready=1 and rs1_busy (rs1=0) stays 0.
- Bypass, BYPASS=1: in a single cycle, rd=7, reg_data3=0xA5A5A5A5, rs2=7 -> reg_data2=0xA5A5A5A5 in that cycle. With BYPASS=0 the same stimulus returns the old value (0) and the new value on the next cycle.
- Scoreboard fill/saturate, CNT_W=2:
  - Issue to x3 three times -> rs1_busy (rs1=3) = 1.
  - Fourth issue to x3 -> iss_ready=0 and the counter stays at 3.
  - Same-cycle issue plus write-back to x3 -> iss_ready=1 and the counter stays at 3.
- Retire: starting from cnt[x4]=1, write-back to x4 with 0x00000042 -> next cycle rs1_busy=0 and reg_data1=0x42. With BYPASS=1, busy is already 0 combinationally in the write-back cycle.
- Underflow: write-back to x9 with no prior issue -> the data is written, err_underflow=1 and stays 1 until RST, and the counter stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default widths and common register/data types.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Architectural register address for the default 32-entry file.
  typedef logic [4:0] reg_addr_t;

  // One data word at the default width.
  typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/sb_counter.sv
// Outstanding-write counter for one architectural register.
// Counts issues up and write-back retires down, saturating at both ends.
module sb_counter
  import core_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,        // accepted issue targeting this register
  input  logic dec_req_i,    // write-back targeting this register
  output logic full_o,       // no more issues can be tracked
  output logic nonzero_o,    // at least one write outstanding
  output logic underflow_o,  // write-back arrived with nothing outstanding
  output logic clears_o      // this edge takes the count from 1 to 0
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dec_w;
  logic             inc_w;

  assign full_o      = (cnt_q == CNT_MAX);
  assign nonzero_o   = (cnt_q != '0);
  assign underflow_o = dec_req_i && (cnt_q == '0);

  // A retire only counts when something is outstanding; an issue onto a full
  // counter is ignored unless a retire frees the slot in the same cycle.
  assign dec_w = dec_req_i && nonzero_o;
  assign inc_w = inc_i && !(full_o && !dec_w);

  assign clears_o = dec_w && !inc_w && (cnt_q == CNT_ONE);

  // Next count: simultaneous increment and decrement cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_w && !dec_w) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec_w && !inc_w) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Counter register, discarded immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write-back port,
// a hard-wired zero register and per-register pending-write tracking used
// by decode to stall on read-after-write hazards.
module regfile_sb
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] reg_data1,
  output logic [XLEN-1:0] reg_data2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] reg_data3,
  output logic            err_underflow
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic            err_underflow_q;

  // Per-register tracking status; entry 0 is tied off (x0 never busy).
  logic [NREG-1:0] full_w;
  logic [NREG-1:0] nonzero_w;
  logic [NREG-1:0] under_w;
  logic [NREG-1:0] clears_w;

  logic wr_en_w;
  logic iss_ready_w;
  logic iss_acc_w;
  logic hit1_w;
  logic hit2_w;

  assign wr_en_w = reg_write && (rd != '0);

  // A full counter blocks issue unless a retire to the same register
  // frees a slot this cycle.
  assign iss_ready_w = !(iss_valid && (iss_rd != '0) && full_w[iss_rd] &&
                         !(reg_write && (rd == iss_rd)));
  assign iss_acc_w   = iss_valid && iss_ready_w;

  assign full_w[0]    = 1'b0;
  assign nonzero_w[0] = 1'b0;
  assign under_w[0]   = 1'b0;
  assign clears_w[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cnt
      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk         (CLK),
        .rst         (RST),
        .inc_i       (iss_acc_w && (iss_rd == AW'(gi))),
        .dec_req_i   (reg_write && (rd == AW'(gi))),
        .full_o      (full_w[gi]),
        .nonzero_o   (nonzero_w[gi]),
        .underflow_o (under_w[gi]),
        .clears_o    (clears_w[gi])
      );
    end
  endgenerate

  // Register storage: cleared on reset, written on the rising edge; x0 is
  // never written so it stays at zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_w) begin
      regs_q[rd] <= reg_data3;
    end
  end

  // Sticky underflow flag: set by any write-back with nothing outstanding.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_underflow_q <= 1'b0;
    end else if (|under_w) begin
      err_underflow_q <= 1'b1;
    end
  end

  assign hit1_w = BYP && wr_en_w && (rd == rs1);
  assign hit2_w = BYP && wr_en_w && (rd == rs2);

  // Read ports with optional same-cycle forwarding; outputs forced to their
  // idle values while reset is held so nothing leaks through the bypass.
  always_comb begin
    reg_data1 = '0;
    reg_data2 = '0;
    rs1_busy  = 1'b0;
    rs2_busy  = 1'b0;
    iss_ready = 1'b1;
    if (!RST) begin
      reg_data1 = hit1_w ? reg_data3 : regs_q[rs1];
      reg_data2 = hit2_w ? reg_data3 : regs_q[rs2];
      rs1_busy  = nonzero_w[rs1] && !(BYP && clears_w[rs1]);
      rs2_busy  = nonzero_w[rs2] && !(BYP && clears_w[rs2]);
      iss_ready = iss_ready_w;
    end
  end

  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a queue-based scoreboard: each stimulus
// cycle pushes its expected outputs, a monitor pops and compares mid-cycle.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [5:0] M_D1  = 6'd1;
  localparam logic [5:0] M_D2  = 6'd2;
  localparam logic [5:0] M_B1  = 6'd4;
  localparam logic [5:0] M_B2  = 6'd8;
  localparam logic [5:0] M_RDY = 6'd16;
  localparam logic [5:0] M_ERR = 6'd32;

  logic            CLK = 1'b0;
  logic            RST;
  logic [AW-1:0]   rs1, rs2, iss_rd, rd;
  logic [XLEN-1:0] reg_data1, reg_data2, reg_data3;
  logic            rs1_busy, rs2_busy, iss_valid, iss_ready, reg_write;
  logic            err_underflow;

  regfile_sb #(
    .XLEN   (32),
    .NREG   (32),
    .CNT_W  (2),
    .BYPASS (1)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .rs1           (rs1),
    .rs2           (rs2),
    .reg_data1     (reg_data1),
    .reg_data2     (reg_data2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .iss_ready     (iss_ready),
    .reg_write     (reg_write),
    .rd            (rd),
    .reg_data3     (reg_data3),
    .err_underflow (err_underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [5:0]  mask;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h want %h", tag, fld, act, want);
    end
  endtask

  // Monitor: outputs are combinational and valid every cycle, so each
  // falling edge consumes the expectation pushed for that cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) cmp(e.tag, "reg_data1", reg_data1, e.d1);
      if (e.mask[1]) cmp(e.tag, "reg_data2", reg_data2, e.d2);
      if (e.mask[2]) cmp(e.tag, "rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1});
      if (e.mask[3]) cmp(e.tag, "rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2});
      if (e.mask[4]) cmp(e.tag, "iss_ready", {31'd0, iss_ready}, {31'd0, e.rdy});
      if (e.mask[5]) cmp(e.tag, "err_underflow", {31'd0, err_underflow}, {31'd0, e.err});
      $display("txn %-12s d1=%h d2=%h b1=%b b2=%b rdy=%b err=%b",
               e.tag, reg_data1, reg_data2, rs1_busy, rs2_busy, iss_ready, err_underflow);
    end
  end

  task automatic drv(input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] ia,
                     input logic [4:0] a1, input logic [4:0] a2);
    reg_write = rw;
    rd        = wa;
    reg_data3 = wd;
    iss_valid = iv;
    iss_rd    = ia;
    rs1       = a1;
    rs2       = a2;
  endtask

  task automatic push_exp(input string tag, input logic [5:0] m,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic eb1, input logic eb2,
                          input logic er, input logic ee);
    exp_t e;
    e.tag = tag; e.mask = m; e.d1 = e1; e.d2 = e2;
    e.b1 = eb1; e.b2 = eb2; e.rdy = er; e.err = ee;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Held in reset: write/issue activity must not reach outputs.
    drv(1, 5, 32'hFFFF0000, 1, 5, 5, 5);
    push_exp("rst_hold", M_D1|M_D2|M_B1|M_B2|M_RDY|M_ERR, 0, 0, 0, 0, 1, 0);
    tick();

    RST = 1'b0;
    drv(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    push_exp("wr_x5", M_D1|M_B1|M_ERR, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 1, 5, 5, 0);
    push_exp("rd_x5_iss", M_D1|M_B1|M_RDY|M_ERR, 32'hDEADBEEF, 0, 0, 0, 1, 1);
    tick();
    drv(0, 0, 0, 0, 0, 5, 0);
    push_exp("x5_busy", M_D1|M_B1|M_ERR, 32'hDEADBEEF, 0, 1, 0, 1, 1);
    tick();

    // Reset asserted between edges clears everything at once.
    RST = 1'b1;
    drv(0, 0, 0, 1, 5, 5, 0);
    push_exp("rst_mid", M_D1|M_B1|M_RDY|M_ERR, 0, 0, 0, 0, 1, 0);
    tick();
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 5, 0);
    push_exp("post_rst", M_D1|M_B1|M_ERR, 0, 0, 0, 0, 1, 0);
    tick();

    // Zero register.
    drv(1, 0, 32'h12345678, 1, 0, 0, 0);
    push_exp("x0_wr_iss", M_D1|M_D2|M_B1|M_RDY, 0, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    push_exp("x0_rd", M_D1|M_B1|M_ERR, 0, 0, 0, 0, 1, 0);
    tick();

    // Bypass on a pending register, retiring 1 -> 0 in the same cycle.
    drv(0, 0, 0, 1, 7, 7, 0);
    push_exp("iss_x7", M_B1|M_RDY, 0, 0, 0, 0, 1, 0);
    tick();
    drv(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
    push_exp("byp_x7", M_D1|M_D2|M_B1|M_B2|M_ERR, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 7);
    push_exp("rd_x7", M_D2|M_B2|M_ERR, 0, 32'hA5A5A5A5, 0, 0, 1, 0);
    tick();

    // Fill x3 to the limit of three outstanding writes.
    drv(0, 0, 0, 1, 3, 3, 0);
    push_exp("iss3_a", M_B1|M_RDY, 0, 0, 0, 0, 1, 0);
    tick();
    push_exp("iss3_b", M_B1|M_RDY, 0, 0, 1, 0, 1, 0);
    tick();
    push_exp("iss3_c", M_B1|M_RDY, 0, 0, 1, 0, 1, 0);
    tick();
    push_exp("iss3_full", M_B1|M_RDY, 0, 0, 1, 0, 0, 0);
    tick();
    push_exp("iss3_full2", M_B1|M_RDY, 0, 0, 1, 0, 0, 0);
    tick();
    drv(1, 3, 32'h00000033, 1, 3, 3, 0);
    push_exp("iss3_wb", M_D1|M_B1|M_RDY, 32'h33, 0, 1, 0, 1, 0);
    tick();
    drv(0, 0, 0, 1, 3, 3, 0);
    push_exp("iss3_still", M_D1|M_B1|M_RDY, 32'h33, 0, 1, 0, 0, 0);
    tick();

    // Drain x3: exactly three retires bring busy down.
    drv(1, 3, 32'h1, 0, 0, 3, 0);
    push_exp("ret3_a", M_D1|M_B1, 32'h1, 0, 1, 0, 1, 0);
    tick();
    drv(1, 3, 32'h2, 0, 0, 3, 0);
    push_exp("ret3_b", M_D1|M_B1, 32'h2, 0, 1, 0, 1, 0);
    tick();
    drv(1, 3, 32'h3, 0, 0, 3, 0);
    push_exp("ret3_c", M_D1|M_B1, 32'h3, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 3, 0);
    push_exp("x3_idle", M_D1|M_B1|M_ERR, 32'h3, 0, 0, 0, 1, 0);
    tick();

    // Retire x4 from a count of one.
    drv(0, 0, 0, 1, 4, 4, 0);
    push_exp("iss_x4", M_B1|M_RDY, 0, 0, 0, 0, 1, 0);
    tick();
    drv(1, 4, 32'h00000042, 0, 0, 4, 0);
    push_exp("ret_x4", M_D1|M_B1, 32'h42, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 4, 0);
    push_exp("rd_x4", M_D1|M_B1|M_ERR, 32'h42, 0, 0, 0, 1, 0);
    tick();

    // Underflow on x9: data still written, flag sticky, counter stays 0.
    drv(1, 9, 32'h00000099, 0, 0, 0, 9);
    push_exp("uf_x9", M_D2|M_B2|M_ERR, 0, 32'h99, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 9);
    push_exp("uf_flag", M_D2|M_B2|M_ERR, 0, 32'h99, 0, 0, 1, 1);
    tick();
    drv(0, 0, 0, 1, 9, 0, 9);
    push_exp("iss_x9", M_B2|M_RDY|M_ERR, 0, 0, 0, 0, 1, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 9);
    push_exp("x9_busy", M_B2|M_ERR, 0, 0, 0, 1, 1, 1);
    tick();
    drv(1, 9, 32'h0000009A, 0, 0, 0, 9);
    push_exp("ret_x9", M_D2|M_B2|M_ERR, 0, 32'h9A, 0, 0, 1, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 9);
    push_exp("x9_idle", M_D2|M_B2|M_ERR, 0, 32'h9A, 0, 0, 1, 1);
    tick();

    RST = 1'b1;
    push_exp("uf_clear", M_D2|M_ERR, 0, 0, 0, 0, 1, 0);
    tick();
    RST = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
